// File: rtl/sn_io_protocol3.sv
// Byte-stream host protocol engine: decodes UART command bytes into register-file accesses
// and streams status/output bytes back, with a watchdog that aborts stalled transactions.
module sn_io_protocol3 #(
  parameter int P_NUM_INPUTS    = 23,
  parameter int P_IN_BYTES      = 3,
  parameter int P_NUM_OUTPUTS   = 3,
  parameter int P_OUT_BYTES     = 1,
  parameter int P_WATCHDOG_TIME = 100
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_data,
  output logic       o_tx_valid,
  input  logic       i_tx_ready,
  output logic [7:0] o_tx_data,
  output logic       o_prot_enable,
  output logic       o_prot_r0w1,
  output logic [6:0] o_prot_addr,
  output logic [7:0] o_prot_wdata,
  input  logic [7:0] i_prot_rdata,
  output logic       o_busy,
  output logic       o_timeout
);

  localparam int          LP_WD_W     = $clog2(P_WATCHDOG_TIME + 1);
  localparam logic [LP_WD_W-1:0] LP_WD_MAX = LP_WD_W'(P_WATCHDOG_TIME);
  localparam logic [1:0]  LP_IN_LAST  = 2'(P_IN_BYTES - 1);
  localparam logic [1:0]  LP_OUT_LAST = 2'(P_OUT_BYTES - 1);
  localparam logic [15:0] LP_IN_MAX   = 16'(P_NUM_INPUTS);
  localparam logic [7:0]  LP_OUT_MAX  = 8'(P_NUM_OUTPUTS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_TS_HI, S_TS_LO, S_WI_IDX_MSB, S_WI_IDX_LSB, S_WI_DATA, S_WI_COMMIT,
    S_EX_START, S_EX_POLL, S_EX_TX, S_RO_SEL, S_RO_RD, S_RO_TX, S_DBG_ADDR, S_DBG_TX
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [15:0]          r_in_idx, w_in_idx_nxt;
  logic [7:0]           r_out_idx, w_out_idx_nxt;
  logic [1:0]           r_byte_cnt, w_byte_cnt_nxt;
  logic [7:0]           r_tx_data, w_tx_data_nxt;
  logic [LP_WD_W-1:0]   r_wdog;
  logic                 w_wd_active, w_expire, w_tx_hold, w_tx_acc;

  // Watchdog only runs in states that wait on the host or on the UART.
  assign w_wd_active = (r_state == S_TS_HI)   || (r_state == S_TS_LO)  ||
                       (r_state == S_WI_DATA) || (r_state == S_EX_POLL) ||
                       (r_state == S_EX_TX)   || (r_state == S_RO_TX)  ||
                       (r_state == S_DBG_ADDR) || (r_state == S_DBG_TX);
  assign w_expire  = w_wd_active && (r_wdog == LP_WD_MAX);
  assign w_tx_hold = (r_state == S_EX_TX) || (r_state == S_RO_TX) || (r_state == S_DBG_TX);

  assign o_tx_valid = w_tx_hold && !w_expire;
  assign o_tx_data  = r_tx_data;
  assign w_tx_acc   = o_tx_valid && i_tx_ready;
  assign o_timeout  = w_expire;
  assign o_busy     = (r_state != S_IDLE);

  always_comb begin
    w_state_nxt    = r_state;
    w_in_idx_nxt   = r_in_idx;
    w_out_idx_nxt  = r_out_idx;
    w_byte_cnt_nxt = r_byte_cnt;
    w_tx_data_nxt  = r_tx_data;
    o_prot_enable  = 1'b0;
    o_prot_r0w1    = 1'b0;
    o_prot_addr    = 7'd0;
    o_prot_wdata   = 8'd0;
    case (r_state)
      S_IDLE: if (i_rx_valid) begin
        case (i_rx_data)
          8'hFF:   w_state_nxt = S_WI_IDX_MSB;
          8'h55:   w_state_nxt = S_TS_HI;
          8'hAA:   w_state_nxt = S_RO_SEL;
          8'h33:   w_state_nxt = S_DBG_ADDR;
          default: w_state_nxt = S_IDLE;
        endcase
      end
      S_TS_HI, S_TS_LO: if (i_rx_valid) begin
        o_prot_enable = 1'b1;
        o_prot_r0w1   = 1'b1;
        o_prot_addr   = (r_state == S_TS_HI) ? 7'd3 : 7'd4;
        o_prot_wdata  = i_rx_data;
        w_state_nxt   = (r_state == S_TS_HI) ? S_TS_LO : S_IDLE;
      end
      S_WI_IDX_MSB, S_WI_IDX_LSB: begin
        o_prot_enable = 1'b1;
        o_prot_r0w1   = 1'b1;
        o_prot_addr   = (r_state == S_WI_IDX_MSB) ? 7'd6 : 7'd7;
        o_prot_wdata  = (r_state == S_WI_IDX_MSB) ? r_in_idx[15:8] : r_in_idx[7:0];
        w_state_nxt   = (r_state == S_WI_IDX_MSB) ? S_WI_IDX_LSB : S_WI_DATA;
      end
      S_WI_DATA: if (i_rx_valid) begin
        o_prot_enable = 1'b1;
        o_prot_r0w1   = 1'b1;
        o_prot_addr   = 7'd8 + 7'(r_byte_cnt);
        o_prot_wdata  = i_rx_data;
        if (r_byte_cnt == LP_IN_LAST) begin
          w_byte_cnt_nxt = 2'd0;
          w_state_nxt    = S_WI_COMMIT;
        end else begin
          w_byte_cnt_nxt = r_byte_cnt + 2'd1;
        end
      end
      S_WI_COMMIT: begin
        o_prot_enable = 1'b1;
        o_prot_r0w1   = 1'b1;
        o_prot_addr   = 7'd5;
        o_prot_wdata  = 8'h01;
        if (r_in_idx == LP_IN_MAX) begin
          w_in_idx_nxt = 16'd1;
          w_state_nxt  = S_EX_START;
        end else begin
          w_in_idx_nxt = r_in_idx + 16'd1;
          w_state_nxt  = S_WI_IDX_MSB;
        end
      end
      S_EX_START: begin
        o_prot_enable = 1'b1;
        o_prot_r0w1   = 1'b1;
        o_prot_addr   = 7'd0;
        o_prot_wdata  = 8'h01;
        w_state_nxt   = S_EX_POLL;
      end
      S_EX_POLL: if (i_rx_valid) begin
        if (i_rx_data == 8'h00) begin
          w_state_nxt = S_IDLE;
        end else begin
          o_prot_enable = 1'b1;
          w_tx_data_nxt = i_prot_rdata;
          w_state_nxt   = S_EX_TX;
        end
      end
      S_EX_TX: if (w_tx_acc) w_state_nxt = (r_tx_data == 8'h00) ? S_RO_SEL : S_EX_POLL;
      S_RO_SEL: begin
        o_prot_enable = 1'b1;
        o_prot_r0w1   = 1'b1;
        o_prot_addr   = 7'd12;
        o_prot_wdata  = r_out_idx;
        w_state_nxt   = S_RO_RD;
      end
      S_RO_RD: begin
        o_prot_enable = 1'b1;
        o_prot_addr   = 7'd13 + 7'(r_byte_cnt);
        w_tx_data_nxt = i_prot_rdata;
        w_state_nxt   = S_RO_TX;
      end
      S_RO_TX: if (w_tx_acc) begin
        if (r_byte_cnt == LP_OUT_LAST) begin
          w_byte_cnt_nxt = 2'd0;
          if (r_out_idx == LP_OUT_MAX) begin
            w_out_idx_nxt = 8'd0;
            w_state_nxt   = S_IDLE;
          end else begin
            w_out_idx_nxt = r_out_idx + 8'd1;
            w_state_nxt   = S_RO_SEL;
          end
        end else begin
          w_byte_cnt_nxt = r_byte_cnt + 2'd1;
          w_state_nxt    = S_RO_RD;
        end
      end
      S_DBG_ADDR: if (i_rx_valid) begin
        o_prot_enable = 1'b1;
        o_prot_addr   = i_rx_data[6:0];
        w_tx_data_nxt = i_prot_rdata;
        w_state_nxt   = S_DBG_TX;
      end
      S_DBG_TX: if (w_tx_acc) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // Expiry overrides whatever the state decoded, including a same-cycle rx byte.
    if (w_expire) begin
      w_state_nxt    = S_IDLE;
      w_in_idx_nxt   = 16'd1;
      w_out_idx_nxt  = 8'd0;
      w_byte_cnt_nxt = 2'd0;
      w_tx_data_nxt  = r_tx_data;
      o_prot_enable  = 1'b0;
      o_prot_r0w1    = 1'b0;
      o_prot_addr    = 7'd0;
      o_prot_wdata   = 8'd0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_in_idx   <= 16'd1;
      r_out_idx  <= 8'd0;
      r_byte_cnt <= 2'd0;
      r_tx_data  <= 8'd0;
      r_wdog     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_idx   <= w_in_idx_nxt;
      r_out_idx  <= w_out_idx_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_tx_data  <= w_tx_data_nxt;
      if (!w_wd_active || i_rx_valid || w_tx_acc || (w_state_nxt != r_state))
        r_wdog <= '0;
      else
        r_wdog <= r_wdog + 1'b1;
    end
  end

endmodule

// File: tb/tb_sn_io_protocol3.sv
// Directed bench for sn_io_protocol3: a small register-file model answers reads, a monitor
// logs every write and every accepted tx byte, and each step compares against fixed values.
module tb_sn_io_protocol3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic [7:0] tx_data;
  logic       prot_enable, prot_r0w1, busy, timeout;
  logic [6:0] prot_addr;
  logic [7:0] prot_wdata, prot_rdata;

  logic [7:0]  mem [0:127];
  logic [7:0]  sel = 8'd0;
  logic [15:0] wq[$];
  logic [7:0]  tq[$];
  int          to_cnt = 0;
  int          total = 0;
  int          bad = 0;

  sn_io_protocol3 #(
    .P_NUM_INPUTS(2), .P_IN_BYTES(3), .P_NUM_OUTPUTS(3), .P_OUT_BYTES(1), .P_WATCHDOG_TIME(100)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
    .o_tx_valid(tx_valid), .i_tx_ready(tx_ready), .o_tx_data(tx_data),
    .o_prot_enable(prot_enable), .o_prot_r0w1(prot_r0w1), .o_prot_addr(prot_addr),
    .o_prot_wdata(prot_wdata), .i_prot_rdata(prot_rdata), .o_busy(busy), .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  // Output byte register 13 reflects whichever output was last selected via register 12.
  assign prot_rdata = (prot_addr == 7'd13) ? (8'hA0 | sel) : mem[prot_addr];

  always @(negedge clk) begin
    if (rst_n) begin
      if (prot_enable && prot_r0w1) begin
        wq.push_back({1'b0, prot_addr, prot_wdata});
        if (prot_addr == 7'd12) sel <= prot_wdata;
      end
      if (tx_valid && tx_ready) tq.push_back(tx_data);
      if (timeout) to_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic chk_wq(input string tag, input logic [15:0] exp[]);
    chk({tag, "_wcount"}, wq.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), (i < wq.size()) ? wq[i] : 16'hxxxx, exp[i]);
  endtask

  task automatic chk_tq(input string tag, input logic [7:0] exp[]);
    chk({tag, "_tcount"}, tq.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s_t%0d", tag, i), (i < tq.size()) ? tq[i] : 8'hxx, exp[i]);
  endtask

  initial begin
    int early;
    int base;
    int unstable;
    for (int i = 0; i < 128; i++) mem[i] = 8'd0;

    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_txv", tx_valid, 1'b0);
    chk("rst_txd", tx_data, 8'd0);
    chk("rst_pen", prot_enable, 1'b0);
    chk("rst_to", timeout, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Timestep load
    wq.delete(); tq.delete();
    send(8'h55); send(8'h01); send(8'hF4); idle(2);
    chk_wq("t1", '{16'h0301, 16'h04F4});
    chk("t1_notx", tq.size(), 0);
    chk("t1_busy", busy, 1'b0);

    // Input stream for two inputs, then start
    wq.delete();
    send(8'hFF); idle(3);
    send(8'h11); send(8'h22); send(8'h33); idle(3);
    send(8'h44); send(8'h55); send(8'h66); idle(3);
    chk_wq("t2", '{16'h0600, 16'h0701, 16'h0811, 16'h0922, 16'h0A33, 16'h0501,
                   16'h0600, 16'h0702, 16'h0844, 16'h0955, 16'h0A66, 16'h0501, 16'h0001});
    chk("t2_busy", busy, 1'b1);

    // Poll: busy, then done, then output readback
    wq.delete(); tq.delete();
    mem[0] = 8'h01;
    send(8'h01); idle(3);
    mem[0] = 8'h00;
    send(8'h01); idle(15);
    chk_tq("t3", '{8'h01, 8'h00, 8'hA0, 8'hA1, 8'hA2});
    chk_wq("t3", '{16'h0C00, 16'h0C01, 16'h0C02});
    chk("t3_busy", busy, 1'b0);

    // Debug peek with back-pressure
    wq.delete(); tq.delete();
    mem[12] = 8'h5A;
    tx_ready = 1'b0;
    send(8'h33); send(8'h0C);
    chk("t4_txv", tx_valid, 1'b1);
    chk("t4_txd", tx_data, 8'h5A);
    unstable = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) mem[12] = 8'h00;
      if (tx_valid !== 1'b1 || tx_data !== 8'h5A || prot_enable !== 1'b0) unstable++;
      idle(1);
    end
    chk("t4_stable", unstable, 0);
    tx_ready = 1'b1;
    idle(2);
    chk_tq("t4", '{8'h5A});
    chk("t4_nowrite", wq.size(), 0);
    chk("t4_busy", busy, 1'b0);

    // Watchdog after 0x55 with no follow-up
    base = to_cnt;
    send(8'h55);
    early = 0;
    for (int i = 0; i < 100; i++) begin
      if (timeout) early++;
      idle(1);
    end
    chk("t5_no_early", early, 0);
    chk("t5_to", timeout, 1'b1);
    chk("t5_pen", prot_enable, 1'b0);
    idle(1);
    chk("t5_to_fall", timeout, 1'b0);
    chk("t5_idle", busy, 1'b0);
    chk("t5_pulses", to_cnt - base, 1);

    // Abort mid-stream, then the next stream restarts at input 1
    send(8'hFF); idle(3);
    send(8'h11); send(8'h22); send(8'h33); idle(3);
    base = to_cnt;
    idle(110);
    chk("t5b_pulse", to_cnt - base, 1);
    chk("t5b_idle", busy, 1'b0);
    wq.delete();
    send(8'hFF); idle(2);
    chk_wq("t5b", '{16'h0600, 16'h0701});
    idle(110);
    chk("t5b_idle2", busy, 1'b0);

    // Reset during output transmission
    tx_ready = 1'b0;
    send(8'hAA); idle(3);
    chk("t6_txd0", tx_data, 8'hA0);
    tx_ready = 1'b1;
    idle(1);
    tx_ready = 1'b0;
    idle(3);
    chk("t6_txv", tx_valid, 1'b1);
    chk("t6_txd1", tx_data, 8'hA1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_txv", tx_valid, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_pen", prot_enable, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tx_ready = 1'b1;
    wq.delete(); tq.delete();
    send(8'hAA); idle(12);
    chk_wq("t6", '{16'h0C00, 16'h0C01, 16'h0C02});
    chk_tq("t6", '{8'hA0, 8'hA1, 8'hA2});
    chk("t6_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
